// File: rtl/stage_monitor_if.sv
// Log readout stream of stage_monitor: FWFT FIFO head with a valid/ready handshake.
interface stage_monitor_if #(
  parameter int unsigned DW = 9
) ();
  logic          log_valid;
  logic          log_ready;
  logic [DW-1:0] log_data;

  modport master (output log_valid, output log_data, input log_ready);
  modport slave  (input log_valid, input log_data, output log_ready);
endinterface

// File: rtl/stage_monitor.sv
// Multi-channel test-stage monitor: samples stage codes on a prescaled tick, logs changes into a
// FIFO and declares PASS/FAIL/TIMEOUT from error flags, pass codes and a progress watchdog.
module stage_monitor #(
  parameter int unsigned NCH             = 2,
  parameter int unsigned STAGE_W         = 8,
  parameter int unsigned SAMPLE_DIV      = 100,
  parameter int unsigned TIMEOUT_SAMPLES = 6400,
  parameter logic [STAGE_W-1:0] PASS_CODE = 8'hFE,
  parameter int unsigned FIFO_DEPTH      = 8,
  localparam int unsigned CW             = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     start,
  input  logic [NCH*STAGE_W-1:0]   stage_in,
  input  logic [NCH-1:0]           err_in,
  stage_monitor_if.master          log_if,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [CW-1:0]            fail_chan,
  output logic                     overflow
);

  localparam int unsigned DW = CW + STAGE_W;
  localparam int unsigned PW = $clog2(SAMPLE_DIV);
  localparam int unsigned WW = (TIMEOUT_SAMPLES > 1) ? $clog2(TIMEOUT_SAMPLES) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PMax = PW'(SAMPLE_DIV - 1);
  localparam logic [WW-1:0] WMax = WW'(TIMEOUT_SAMPLES - 1);
  localparam logic [AW:0]   Full = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StRun, StPass, StFail, StTimeout} state_e;

  state_e                        state_q, state_d;
  logic [PW-1:0]                 presc_q, presc_d;
  logic [WW-1:0]                 wdog_q, wdog_d;
  logic [NCH-1:0][STAGE_W-1:0]   last_q, last_d;
  logic [AW-1:0]                 wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]                   cnt_q, cnt_d;
  logic                          ovf_q, ovf_d;
  logic [CW-1:0]                 fchan_q, fchan_d;
  logic [DW-1:0]                 mem_q [FIFO_DEPTH];

  logic                err_any, all_pass, chg_any, tick, pop, push, wr_en;
  logic [CW-1:0]       err_idx, chg_idx;
  logic [STAGE_W-1:0]  chg_stage;
  logic [DW-1:0]       wr_data;

  // Descending scans so the lowest matching channel index is the one left standing.
  always_comb begin
    err_any   = |err_in;
    err_idx   = '0;
    all_pass  = 1'b1;
    chg_any   = 1'b0;
    chg_idx   = '0;
    chg_stage = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (err_in[c]) err_idx = CW'(c);
      if (stage_in[c*STAGE_W +: STAGE_W] != PASS_CODE) all_pass = 1'b0;
      if (stage_in[c*STAGE_W +: STAGE_W] != last_q[c]) begin
        chg_any   = 1'b1;
        chg_idx   = CW'(c);
        chg_stage = stage_in[c*STAGE_W +: STAGE_W];
      end
    end
  end

  assign tick    = (state_q == StRun) && (presc_q == PMax);
  assign pop     = (cnt_q != '0) && log_if.log_ready;
  assign wr_data = {chg_idx, chg_stage};

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    wdog_d  = wdog_q;
    last_d  = last_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    fchan_d = fchan_q;
    push    = 1'b0;
    wr_en   = 1'b0;
    if (start && (state_q != StRun)) begin
      state_d = StRun;
      presc_d = '0;
      wdog_d  = '0;
      last_d  = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      fchan_d = '0;
    end else begin
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
        cnt_d  = cnt_q - 1'b1;
      end
      if (state_q == StRun) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          if (err_any) begin
            state_d = StFail;
            fchan_d = err_idx;
          end else begin
            // A full FIFO still accepts the push when the head leaves in the same cycle.
            if (chg_any) begin
              if ((cnt_q != Full) || pop) begin
                push              = 1'b1;
                wr_en             = 1'b1;
                wptr_d            = wptr_q + 1'b1;
                cnt_d             = cnt_d + 1'b1;
                last_d[chg_idx]   = chg_stage;
              end else begin
                ovf_d = 1'b1;
              end
            end
            if (push)                wdog_d = '0;
            else if (wdog_q != WMax) wdog_d = wdog_q + 1'b1;
            if (all_pass)                        state_d = StPass;
            else if (!push && (wdog_q == WMax))  state_d = StTimeout;
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      presc_q <= '0;
      wdog_q  <= '0;
      last_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      fchan_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      wdog_q  <= wdog_d;
      last_q  <= last_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      fchan_q <= fchan_d;
    end
  end

  // Storage needs no reset: contents are only visible through a non-zero count.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) mem_q[wptr_q] <= wr_data;
  end

  assign log_if.log_valid = (cnt_q != '0);
  assign log_if.log_data  = (cnt_q != '0) ? mem_q[rptr_q] : '0;

  assign busy      = (state_q == StRun);
  assign pass      = (state_q == StPass);
  assign fail      = (state_q == StFail);
  assign timeout   = (state_q == StTimeout);
  assign done      = pass || fail || timeout;
  assign fail_chan = fchan_q;
  assign overflow  = ovf_q;

endmodule
